// File: rtl/vector_norm_calc.sv
// -----------------------------------------------------------------------------
// vector_norm_calc
//
// Computes the Euclidean norm of an N_CH-component signed fixed-point vector,
// together with the per-channel squares.
// - One shared multiplier squares one channel per cycle.
// - A bit-serial restoring square root runs one result bit per cycle.
// - The final SQRT cycle registers the conversion of the squares and the norm
//   to the unsigned output format, with saturation.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   in_data    : packed signed components, channel k at [k*IN_W +: IN_W]
//   in_valid   : in_data is valid
//   in_ready   : block is idle and accepts a vector
//   out_ready  : downstream accepts the result
//   out_valid  : result is valid (held until out_ready)
//   out_norm   : unsigned norm, OUT_FRAC fractional bits
//   out_sq     : packed unsigned per-channel squares, same packing as in_data
//   out_sat    : saturation flags; bit k = square of channel k, bit N_CH = norm
// -----------------------------------------------------------------------------
module vector_norm_calc #(
    parameter int N_CH     = 3,
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH*IN_W-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_norm,
    output logic [N_CH*OUT_W-1:0]  out_sq,
    output logic [N_CH:0]          out_sat
);

    localparam int SQ_W    = 2 * IN_W;
    localparam int SQ_FRAC = 2 * IN_FRAC;
    localparam int SUM_W   = SQ_W + $clog2(N_CH);
    localparam int R_W     = (SUM_W + 1) / 2;
    // The radicand is consumed two bits per iteration, so it is held in an
    // even width that may carry one extra zero MSB.
    localparam int ACC_W   = 2 * R_W;
    // The remainder never exceeds 2*root, which needs R_W+1 bits.
    localparam int REM_W   = R_W + 1;
    localparam int CH_W    = $clog2(N_CH);
    localparam int BIT_W   = $clog2(R_W + 1);
    // Wide enough to align any intermediate value without losing bits.
    localparam int EXT_W   = ACC_W + OUT_W + OUT_FRAC;

    localparam int SQ_LSH   = (OUT_FRAC > SQ_FRAC) ? (OUT_FRAC - SQ_FRAC) : 0;
    localparam int SQ_RSH   = (SQ_FRAC > OUT_FRAC) ? (SQ_FRAC - OUT_FRAC) : 0;
    localparam int NORM_LSH = (OUT_FRAC > IN_FRAC) ? (OUT_FRAC - IN_FRAC) : 0;
    localparam int NORM_RSH = (IN_FRAC > OUT_FRAC) ? (IN_FRAC - OUT_FRAC) : 0;

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        SQRT,
        DONE
    } state_e;

    // Aligns a value to OUT_FRAC fractional bits (floor on reduction, zero
    // fill on extension) and saturates to OUT_W bits.
    // Returns {sat, value}.
    function automatic logic [OUT_W:0] to_out(input logic [EXT_W-1:0] v,
                                              input int unsigned     lsh,
                                              input int unsigned     rsh);
        logic [EXT_W-1:0] a;
        a = (v << lsh) >> rsh;
        if (|(a >> OUT_W)) begin
            return {1'b1, {OUT_W{1'b1}}};
        end
        return {1'b0, a[OUT_W-1:0]};
    endfunction

    state_e                    state_q;
    logic [CH_W-1:0]           ch_q;
    logic [BIT_W-1:0]          bit_q;
    logic signed [IN_W-1:0]    in_q [N_CH];
    logic [SQ_W-1:0]           sq_q [N_CH];
    logic [ACC_W-1:0]          acc_q;
    logic [REM_W-1:0]          rem_q;
    logic [R_W-1:0]            root_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [OUT_W-1:0]          out_norm_q;
    logic [N_CH*OUT_W-1:0]     out_sq_q;
    logic [N_CH:0]             out_sat_q;

    logic signed [IN_W-1:0]    ch_val;
    logic signed [SQ_W-1:0]    prod;
    logic [SQ_W-1:0]           sq_d;
    logic [REM_W+1:0]          rem_shift;
    logic [REM_W+1:0]          trial;
    logic [REM_W-1:0]          rem_d;
    logic [R_W-1:0]            root_d;
    logic [OUT_W:0]            norm_conv;
    logic [OUT_W:0]            sq_conv;
    logic [OUT_W-1:0]          out_norm_d;
    logic [N_CH*OUT_W-1:0]     out_sq_d;
    logic [N_CH:0]             out_sat_d;

    // NOTE: every signal driven here gets a default assignment at the top, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        ch_val     = in_q[ch_q];
        // Signed operands in a SQ_W-wide context: the most negative input
        // squares to 2^(2*IN_W-2), which still fits.
        prod       = ch_val * ch_val;
        sq_d       = prod;

        // One restoring step: bring down the next two radicand bits and try
        // to subtract (4*root + 1).
        rem_shift  = {rem_q, acc_q[ACC_W-1 -: 2]};
        trial      = {1'b0, root_q, 2'b01};
        rem_d      = REM_W'(rem_shift);
        root_d     = {root_q[R_W-2:0], 1'b0};
        if (rem_shift >= trial) begin
            rem_d  = REM_W'(rem_shift - trial);
            root_d = {root_q[R_W-2:0], 1'b1};
        end

        out_sq_d  = '0;
        out_sat_d = '0;
        sq_conv   = '0;
        for (int k = 0; k < N_CH; k++) begin
            sq_conv = to_out(EXT_W'(sq_q[k]), SQ_LSH, SQ_RSH);
            out_sq_d[k*OUT_W +: OUT_W] = sq_conv[OUT_W-1:0];
            out_sat_d[k]               = sq_conv[OUT_W];
        end
        norm_conv       = to_out(EXT_W'(root_q), NORM_LSH, NORM_RSH);
        out_norm_d      = norm_conv[OUT_W-1:0];
        out_sat_d[N_CH] = norm_conv[OUT_W];
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            bit_q       <= '0;
            // NOTE: the operand and square arrays are only a few registers, so
            // they are reset with the rest of the state; a large RAM would
            // not be.
            for (int k = 0; k < N_CH; k++) begin
                in_q[k] <= '0;
                sq_q[k] <= '0;
            end
            acc_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_norm_q  <= '0;
            out_sq_q    <= '0;
            out_sat_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        for (int k = 0; k < N_CH; k++) begin
                            in_q[k] <= in_data[k*IN_W +: IN_W];
                        end
                        acc_q      <= '0;
                        rem_q      <= '0;
                        root_q     <= '0;
                        ch_q       <= '0;
                        bit_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SQUARE;
                    end
                end

                SQUARE: begin
                    sq_q[ch_q] <= sq_d;
                    acc_q      <= acc_q + ACC_W'(sq_d);
                    if (ch_q == CH_W'(N_CH - 1)) begin
                        state_q <= SQRT;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end

                SQRT: begin
                    // R_W iterations, then one cycle that registers the
                    // converted results into the output registers.
                    if (bit_q == BIT_W'(R_W)) begin
                        out_norm_q  <= out_norm_d;
                        out_sq_q    <= out_sq_d;
                        out_sat_q   <= out_sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q  <= rem_d;
                        root_q <= root_d;
                        acc_q  <= acc_q << 2;
                        bit_q  <= bit_q + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_norm  = out_norm_q;
    assign out_sq    = out_sq_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vector_norm_calc.sv
// -----------------------------------------------------------------------------
// tb_vector_norm_calc
//
// Directed bench for vector_norm_calc at default parameters (N_CH=3, IN_W=8,
// IN_FRAC=4, OUT_W=8, OUT_FRAC=4): reset state, hand-computed vectors,
// back-pressure hold, reset abort, then randomly generated vectors compared
// against an integer reference model.
// -----------------------------------------------------------------------------
module tb_vector_norm_calc;

    logic        clk;
    logic        reset;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_norm;
    logic [23:0] out_sq;
    logic [3:0]  out_sat;

    int passed = 0;
    int total  = 0;

    vector_norm_calc dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_norm  (out_norm),
        .out_sq    (out_sq),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Integer reference: {sat[3:0], norm[7:0], sq[23:0]}.
    function automatic logic [35:0] model(input logic [23:0] d);
        int          s;
        int          c;
        int          q;
        int          r;
        logic [3:0]  sat;
        logic [23:0] sq;
        logic [7:0]  nrm;
        s   = 0;
        sat = '0;
        sq  = '0;
        for (int k = 0; k < 3; k++) begin
            c = int'($signed(d[k*8 +: 8]));
            q = (c * c) >>> 4;
            if (q > 255) begin
                q      = 255;
                sat[k] = 1'b1;
            end
            sq[k*8 +: 8] = q[7:0];
            s += c * c;
        end
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        if (r > 255) begin
            r      = 255;
            sat[3] = 1'b1;
        end
        nrm = r[7:0];
        return {sat, nrm, sq};
    endfunction

    // Called at a falling edge. Presents d, waits for acceptance, then counts
    // rising edges until out_valid is seen (bounded).
    task automatic send(input logic [23:0] d, input bit keep_valid,
                        input bit rand_ready, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'(1));
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 24'($urandom);
        if (!keep_valid) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Completes the output handshake; returns at a falling edge after out_valid drops.
    task automatic finish_vec(input bit rand_ready);
        int w;
        w = 0;
        do begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            @(negedge clk);
            w++;
        end while (out_valid && w < 100);
        check("release", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int          lat;
        bit          held_ok;
        bit          stray;
        logic [23:0] d;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3 reset = 1'b0;
        #10;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_outputs", {28'd0, out_sat, out_norm, out_sq}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // (3,4,0): norm 5.0, 3^2=9.0, 4^2=16.0 saturates
        send(24'h004030, 1'b0, 1'b0, lat);
        check("v345_latency", 64'(lat), 64'(13));
        check("v345_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0010, 8'h50, 24'h00FF90});
        finish_vec(1'b0);

        // (-3,-4,0): identical result
        send(24'h00C0D0, 1'b0, 1'b0, lat);
        check("vneg345_latency", 64'(lat), 64'(13));
        check("vneg345_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0010, 8'h50, 24'h00FF90});
        finish_vec(1'b0);

        // Most negative inputs: sqrt(192)=13.856 -> floor 13.8125
        send(24'h808080, 1'b0, 1'b0, lat);
        check("vmin_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0111, 8'hDD, 24'hFFFFFF});
        finish_vec(1'b0);

        // (1,1,1): sqrt(3)=1.732 -> 27/16
        send(24'h101010, 1'b0, 1'b0, lat);
        check("v111_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0000, 8'h1B, 24'h101010});
        finish_vec(1'b0);

        // LSB only: square 1/256 truncates to 0, norm 1/16
        send(24'h000001, 1'b0, 1'b0, lat);
        check("vlsb_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0000, 8'h01, 24'h000000});
        finish_vec(1'b0);

        send(24'h000000, 1'b0, 1'b0, lat);
        check("vzero_result", {28'd0, out_sat, out_norm, out_sq}, 64'd0);
        finish_vec(1'b0);

        // Back-pressure: hold DONE for 20 cycles while in_valid toggles
        out_ready = 1'b0;
        send(24'h004030, 1'b0, 1'b0, lat);
        check("hold_latency", 64'(lat), 64'(13));
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (!(out_valid && !in_ready && out_norm == 8'h50 && out_sq == 24'h00FF90 &&
                  out_sat == 4'b0010)) held_ok = 1'b0;
        end
        check("hold_stable", 64'(held_ok), 64'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        stray = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid || !in_ready) stray = 1'b1;
        end
        check("hold_no_stray_vector", 64'(stray), 64'(0));

        // Reset during SQRT aborts the vector and clears the outputs
        in_data  = 24'h808080;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_outputs", {27'd0, out_valid, out_sat, out_norm, out_sq}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        send(24'h000010, 1'b0, 1'b0, lat);
        check("after_abort_latency", 64'(lat), 64'(13));
        check("after_abort_result", {28'd0, out_sat, out_norm, out_sq}, {28'd0, 4'b0000, 8'h10, 24'h000010});
        finish_vec(1'b0);

        // Random vectors, in_valid held high, random out_ready
        for (int i = 0; i < 300; i++) begin
            d = 24'($urandom);
            send(d, 1'b1, 1'b1, lat);
            check("rand_vec", {20'd0, lat[7:0], out_sat, out_norm, out_sq}, {20'd0, 8'd13, model(d)});
            finish_vec(1'b1);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
